scan_sequencer: RTL

Registered select-line sequencer that sits directly upstream of the 4-to-16 demux decoder and drives its `s0..s3` select inputs. It walks the 16 decoder outputs in ascending index order and holds each channel for a programmable dwell time. Channels can be skipped via a mask, and the walk runs either as one sweep or continuously. It also provides `en` (which gates the decoder's data input), `busy` and a one-cycle `done` pulse for the controller.

---
 rtl/scan_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// Select-line sequencer for the 4-to-16 demux decoder: walks unmasked channels in
// ascending order, holding each for dwell+1 cycles, as one sweep or continuously.
//
// state | meaning
// IDLE  | not presenting; sel holds its last value; waits for start
// SCAN  | presenting channel sel for dwell_q+1 cycles (plus held cycles)
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        skip_mask,
    output logic               s0,
    output logic               s1,
    output logic               s2,
    output logic               s3,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic [15:0]        mask_q, mask_d;
    logic               done_q, done_d;

    logic [3:0]         first_in;
    logic               any_in;
    logic [3:0]         first_cap;
    logic [3:0]         next_idx;
    logic               any_next;

    // Descending loop so the last hit is the lowest qualifying index.
    always_comb begin
        first_in  = '0;
        any_in    = 1'b0;
        first_cap = '0;
        next_idx  = '0;
        any_next  = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!skip_mask[i]) begin
                first_in = 4'(i);
                any_in   = 1'b1;
            end
            if (!mask_q[i]) begin
                first_cap = 4'(i);
            end
            if (!mask_q[i] && (4'(i) > sel_q)) begin
                next_idx = 4'(i);
                any_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (any_in) begin
                        state_d = SCAN;
                        sel_d   = first_in;
                        cnt_d   = dwell;
                        dwell_d = dwell;
                        mode_d  = mode;
                        mask_d  = skip_mask;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (any_next) begin
                        sel_d = next_idx;
                        cnt_d = dwell_q;
                    end else if (mode_q) begin
                        sel_d = first_cap;
                        cnt_d = dwell_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    // s0 is the MSB of the channel index, as the decoder expects.
    assign {s0, s1, s2, s3} = sel_q;
    assign en   = (state_q == SCAN);
    assign busy = (state_q == SCAN);
    assign done = done_q;

endmodule
